// File: rtl/detector_ctrl_pkg.sv
// detector_ctrl_pkg: shared state encoding and hit-count limits for the detector run controller
package detector_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} run_state_t;
   localparam int HIT_MAX = 99;
   localparam int HIT_W = 7;
endpackage

// File: rtl/detector_run_ctrl_if.sv
// detector_run_ctrl_if: host request/status and detector drive signals of one run controller
interface detector_run_ctrl_if import detector_ctrl_pkg::*; #(parameter int WIDTH = 24) ();
   localparam int LEN_W = $clog2(WIDTH + 1);
   logic start;
   logic abort;
   logic [WIDTH-1:0] pattern;
   logic [LEN_W-1:0] len;
   logic det_z;
   logic det_rst;
   logic det_ena;
   logic det_sig;
   logic busy;
   logic done;
   logic [HIT_W-1:0] hit_count;
   modport master (output start, abort, pattern, len, det_z,
                   input det_rst, det_ena, det_sig, busy, done, hit_count);
   modport slave (input start, abort, pattern, len, det_z,
                  output det_rst, det_ena, det_sig, busy, done, hit_count);
endinterface

// File: rtl/detector_run_ctrl_hit_counter.sv
// hit_counter: saturating detection counter with synchronous clear and enable
module hit_counter import detector_ctrl_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic [HIT_W-1:0] cnt
);
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en && cnt != HIT_W'(HIT_MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/detector_run_ctrl.sv
// detector_run_ctrl: runs one sequence_detector test by clearing it, feeding a pattern LSB-first and counting z pulses
module detector_run_ctrl import detector_ctrl_pkg::*; #(
   parameter int WIDTH = 24,
   parameter int CLR_CYCLES = 2,
   parameter int DRAIN_CYCLES = 1
) (
   input logic clk,
   input logic rst,
   detector_run_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(WIDTH + 1);
   localparam int PH_MAX = WIDTH > CLR_CYCLES ? (WIDTH > DRAIN_CYCLES ? WIDTH : DRAIN_CYCLES)
                                              : (CLR_CYCLES > DRAIN_CYCLES ? CLR_CYCLES : DRAIN_CYCLES);
   localparam int PH_W = $clog2(PH_MAX + 1);
   run_state_t state;
   logic [WIDTH-1:0] sr;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_c;
   logic [PH_W-1:0] ph;
   logic [HIT_W-1:0] hits;
   logic accept;
   logic count_en;
   logic in_run;
   assign len_c = bus.len > LEN_W'(WIDTH) ? LEN_W'(WIDTH) : bus.len;
   assign accept = state == IDLE && bus.start;
   assign in_run = state == CLEAR || state == FEED || state == DRAIN;
   // an aborting cycle freezes the count, so its z is not taken
   assign count_en = (state == FEED || state == DRAIN) && bus.det_z && !bus.abort;
   assign bus.hit_count = hits;
   hit_counter u_hits (.clk(clk), .rst(rst), .clr(accept), .en(count_en), .cnt(hits));
   // ph counts down the remaining cycles of the current phase
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         bus.det_rst <= 1'b1;
         bus.det_ena <= 1'b0;
         bus.det_sig <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         sr <= '0;
         len_q <= '0;
         ph <= '0;
      end else if (bus.abort && in_run) begin
         state <= IDLE;
         bus.det_rst <= 1'b1;
         bus.det_ena <= 1'b0;
         bus.det_sig <= 1'b0;
         bus.busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.det_rst <= 1'b0;
               if (bus.start) begin
                  state <= len_c == '0 ? DONE : CLEAR;
                  bus.det_rst <= len_c != '0;
                  bus.done <= len_c == '0;
                  bus.busy <= 1'b1;
                  sr <= bus.pattern;
                  len_q <= len_c;
                  ph <= PH_W'(CLR_CYCLES - 1);
               end
            end
            CLEAR:
               if (ph == '0) begin
                  state <= FEED;
                  bus.det_rst <= 1'b0;
                  bus.det_ena <= 1'b1;
                  bus.det_sig <= sr[0];
                  sr <= sr >> 1;
                  ph <= PH_W'(len_q - 1'b1);
               end else ph <= ph - 1'b1;
            FEED:
               if (ph == '0) begin
                  bus.det_ena <= 1'b0;
                  bus.det_sig <= 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     state <= DRAIN;
                     ph <= PH_W'(DRAIN_CYCLES - 1);
                  end
               end else begin
                  bus.det_sig <= sr[0];
                  sr <= sr >> 1;
                  ph <= ph - 1'b1;
               end
            DRAIN:
               if (ph == '0) begin
                  state <= DONE;
                  bus.done <= 1'b1;
               end else ph <= ph - 1'b1;
            DONE: begin
               state <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: doc/detector_run_ctrl.md
# detector_run_ctrl

Controller that runs one test of the `sequence_detector` datapath.
- On `start`, it captures a parallel pattern, clears the detector, and serially feeds the pattern LSB-first, one bit per cycle.
- It counts the detector's `z` pulses and reports completion with a one-cycle `done`.
- It sits between a host/CSR interface and the detector, and is the only driver of the detector's `rst`, `ena` and `sig_to_test`.

## Interface
- `WIDTH`, default 24: maximum pattern length in bits.
- `CLR_CYCLES`, default 2: number of cycles `det_rst` is held high before feeding starts (≥1).
- `DRAIN_CYCLES`, default 1: cycles after the last bit during which `det_z` is still counted (≥0).
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: run request; sampled only in IDLE.
- `abort  in  1`: cancels a run in progress.
- `pattern  in  WIDTH`: bit stream; bit 0 is sent first; captured on accepted `start`.
- `len  in  $clog2(WIDTH+1)`: number of bits to send; captured on accepted `start`.
- `det_z  in  1`: detector sequence flag (Mealy output).
- `det_rst  out  1`: detector reset.
- `det_ena  out  1`: detector enable.
- `det_sig  out  1`: detector serial input (`sig_to_test`).
- `busy  out  1`: high from the cycle after accepted `start` until DONE.
- `done  out  1`: one-cycle pulse at the end of a completed run.
- `hit_count  out  7`: detections in the last/current run; saturates at 99.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `len`≠0: capture `pattern` and `len`, clear `hit_count`, go to CLEAR.
  - `start`=1 and `len`=0: clear `hit_count`, go directly to DONE (no detector activity).
- **CLEAR**
  - `det_rst`=1, `det_ena`=0, `det_sig`=0 for exactly CLR_CYCLES cycles, then go to FEED.
- **FEED**
  - `det_ena`=1 and `det_rst`=0.
  - `det_sig` = captured bit i in the i-th FEED cycle, i = 0..len−1.
  - After `len` cycles: go to DRAIN, or to DONE if DRAIN_CYCLES=0.
- **DRAIN**
  - `det_ena`=0, `det_sig`=0, for DRAIN_CYCLES cycles, then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
  - `hit_count` holds its value until the next accepted `start`.
- **Counting**
  - `hit_count` increments by 1 on each rising edge where state ∈ {FEED, DRAIN} and `det_z`=1.
  - Saturates at 99 to match the two-digit display.
  - `det_z` is ignored in all other states.
- **Abort**
  - `abort`=1 in CLEAR, FEED or DRAIN: next state is IDLE, no `done` pulse, `hit_count` frozen.
  - `det_rst` is pulsed for 1 cycle on the transition to IDLE.
  - `abort` has no effect in IDLE or DONE.
- **Simultaneous `start` and `abort` in IDLE:** `start` wins.
- **`start` outside IDLE:** ignored; it is not queued.
- **`len` > WIDTH:** clamped to WIDTH at capture.

## Timing
- Reset values, and values while `rst`=1 (overrides all inputs): state IDLE, `det_rst`=1, `det_ena`=0, `det_sig`=0, `busy`=0, `done`=0, `hit_count`=0.
- First cycle after `rst` deasserts: `det_rst`=0.
- All outputs are registered, with no combinational paths from input to output.
- Run latency:
  - `start` accepted at edge T → `det_rst` high on cycles T+1..T+CLR_CYCLES.
  - First bit on `det_sig` at T+CLR_CYCLES+1.
  - `done` at T+CLR_CYCLES+len+DRAIN_CYCLES+1.
- `busy` is high on every cycle from T+1 through the `done` cycle inclusive.
- `det_z` is sampled on the same edge that ends the cycle carrying the corresponding `det_sig` bit.
- A new run can be accepted on the cycle after `done`.

## Structure
- Package `detector_ctrl_pkg`:
  - state enum `run_state_t` (IDLE, CLEAR, FEED, DRAIN, DONE)
  - `HIT_MAX` = 99
  - `HIT_W` = 7
- Sub-module `hit_counter`: saturating counter with synchronous clear and enable inputs, instantiated once.
- Top level holds the FSM, the phase cycle counter, and the pattern shift register.

## Test plan
- Reset mid-FEED:
  - Stimulus: `rst`=1 for 1 cycle at FEED bit 5.
  - Required: next cycle state IDLE, `hit_count`=0, `det_rst`=1, no `done`.
- Nominal run:
  - Stimulus: `pattern`=24'b000100110001011101010011, `len`=24, bench `det_z` pulses at FEED bits 3, 9, 17.
  - Required: `det_sig` reproduces bits 1,1,0,0,1,…; `hit_count`=3; `done` exactly 2+24+1+1=28 cycles after `start`.
- Zero/over length:
  - `len`=0 → `done` on the next cycle, `det_rst` never pulses.
  - `len`=30 → exactly 24 FEED cycles.
- Saturation: `det_z` held 1 through `len`=24 on two back-to-back runs → `hit_count`=24 each run; with `WIDTH`=128, `len`=120 → `hit_count`=99.
- Abort: `abort` at FEED bit 10 with 2 prior hits → IDLE, `hit_count`=2, no `done`, single `det_rst` pulse; `start` during `busy` is ignored.
- Drain capture: `det_z` pulses only in the DRAIN cycle → counted (`hit_count`=1); a pulse in DONE or IDLE is not counted.
